// File: rtl/credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : credit_link_tx
// Description : Transmitter side of a credit-based stream link. Converts a
//               valid/ready stream into a valid-only fixed-latency link and
//               throttles itself with a credit counter that is replenished
//               by pulses returned from the receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_link_tx #(
  parameter int DATA_WIDTH   = 11,
  parameter int CREDITS      = 16,
  parameter int LINK_LATENCY = 4,
  localparam int CNT_WIDTH   = $clog2(CREDITS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] link_data_o,
  output logic                  link_valid_o,
  input  logic                  credit_i,
  output logic [CNT_WIDTH-1:0]  credits_o,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam logic [CNT_WIDTH:0]   CREDITS_EXT = (CNT_WIDTH + 1)'(CREDITS);
  localparam logic [CNT_WIDTH-1:0] CREDITS_CNT = CNT_WIDTH'(CREDITS);

  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  err_q;
  logic                  err_d;
  logic                  accept;
  logic                  overflow;
  logic [CNT_WIDTH:0]    cnt_sum;
  logic [LINK_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0] data_q [LINK_LATENCY];

  // Ready depends only on the registered count, never on credit_i/valid_i.
  assign ready_o = (cnt_q != '0);
  assign accept  = valid_i & ready_o;

  // Next credit count; one extra bit so an unexpected credit at full count
  // is detected instead of wrapping. Underflow cannot happen because accept
  // is blocked at zero.
  always_comb begin
    cnt_sum  = {1'b0, cnt_q}
             - {{CNT_WIDTH{1'b0}}, accept}
             + {{CNT_WIDTH{1'b0}}, credit_i};
    overflow = (cnt_sum > CREDITS_EXT);
    cnt_d    = overflow ? CREDITS_CNT : cnt_sum[CNT_WIDTH-1:0];
    err_d    = err_q | overflow;
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CREDITS_CNT;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Forward pipeline: stage 0 captures accepted words, later stages shift
  // unconditionally since the link has no back-pressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < LINK_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < LINK_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign link_valid_o = vld_q[LINK_LATENCY-1];
  assign link_data_o  = data_q[LINK_LATENCY-1];
  assign credits_o    = cnt_q;
  assign err_o        = err_q;
  assign idle_o       = (cnt_q == CREDITS_CNT) && (vld_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_link_tx
// Description : Self-checking bench for credit_link_tx. A reference credit
//               model and a scoreboard of in-flight words (with due cycle)
//               are checked every cycle; directed steps cover the corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_link_tx;

  localparam int DW  = 11;
  localparam int CR  = 16;
  localparam int LAT = 4;
  localparam int CW  = $clog2(CR + 1);

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] link_data_o;
  logic          link_valid_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
  logic          idle_o;
  logic          err_o;

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  int  m_cnt  = CR;
  bit  m_err  = 1'b0;
  sb_t sb[$];

  credit_link_tx #(
    .DATA_WIDTH  (DW),
    .CREDITS     (CR),
    .LINK_LATENCY(LAT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .link_data_o (link_data_o),
    .link_valid_o(link_valid_o),
    .credit_i    (credit_i),
    .credits_o   (credits_o),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: credit count, sticky error and expected link words.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cnt = CR;
      m_err = 1'b0;
      sb.delete();
    end else begin
      bit acc;
      int nxt;
      sb_t e;
      cyc = cyc + 1;
      acc = valid_i && (m_cnt != 0);
      if (acc) begin
        e.data = data_i;
        e.due  = cyc + LAT - 1;
        sb.push_back(e);
      end
      nxt = m_cnt - (acc ? 1 : 0) + (credit_i ? 1 : 0);
      if (nxt > CR) begin
        nxt   = CR;
        m_err = 1'b1;
      end
      m_cnt = nxt;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    bit exp_v;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    check("ready",   32'(ready_o),   32'(m_cnt != 0));
    check("credits", 32'(credits_o), 32'(m_cnt));
    check("err",     32'(err_o),     32'(m_err));
    check("idle",    32'(idle_o),    32'((m_cnt == CR) && (sb.size() == 0)));
    check("link_valid", 32'(link_valid_o), 32'(exp_v));
    if (exp_v) begin
      check("link_data", 32'(link_data_o), 32'(sb[0].data));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("word_lost", 32'(sb[0].data), 32'hFFFF_FFFF);
      void'(sb.pop_front());
    end
  end

  task automatic step();
    @(negedge clk_i);
    #2;
  endtask

  initial begin
    int  k;
    bit  r;

    rst_ni   = 1'b0;
    valid_i  = 1'b0;
    credit_i = 1'b0;
    data_i   = '0;
    repeat (3) @(posedge clk_i);
    step();
    rst_ni = 1'b1;
    step();
    check("rst_ready",   32'(ready_o),      32'd1);
    check("rst_credits", 32'(credits_o),    32'd16);
    check("rst_lvalid",  32'(link_valid_o), 32'd0);
    check("rst_ldata",   32'(link_data_o),  32'd0);
    check("rst_idle",    32'(idle_o),       32'd1);
    check("rst_err",     32'(err_o),        32'd0);

    // Single word; latency and data are checked by the scoreboard.
    valid_i = 1'b1;
    data_i  = 11'h2A5;
    step();
    valid_i = 1'b0;
    check("one_credits", 32'(credits_o), 32'd15);
    check("one_idle",    32'(idle_o),    32'd0);
    repeat (5) step();
    check("one_idle_wait", 32'(idle_o), 32'd0);
    credit_i = 1'b1;
    step();
    credit_i = 1'b0;
    check("one_ret_credits", 32'(credits_o), 32'd16);
    check("one_ret_idle",    32'(idle_o),    32'd1);

    // Burst of increasing words with no returned credits.
    k = 0;
    r = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (r) k++;
      r       = ready_o;
      valid_i = 1'b1;
      data_i  = DW'(k);
    end
    step();
    if (r) k++;
    data_i = DW'(k);
    check("burst_accepted", 32'(k),         32'd16);
    check("burst_ready",    32'(ready_o),   32'd0);
    check("burst_credits",  32'(credits_o), 32'd0);
    repeat (4) step();
    credit_i = 1'b1;
    step();
    credit_i = 1'b0;
    check("credit_ready", 32'(ready_o), 32'd1);
    step();
    valid_i = 1'b0;
    check("word16_credits", 32'(credits_o), 32'd0);

    // Bring the count to 5, then accept and return in the same cycle.
    credit_i = 1'b1;
    repeat (5) step();
    credit_i = 1'b0;
    check("five_credits", 32'(credits_o), 32'd5);
    valid_i  = 1'b1;
    credit_i = 1'b1;
    data_i   = 11'h155;
    step();
    valid_i  = 1'b0;
    credit_i = 1'b0;
    check("same_credits", 32'(credits_o), 32'd5);
    check("same_ready",   32'(ready_o),   32'd1);

    // Refill to full, then overflow.
    repeat (6) step();
    credit_i = 1'b1;
    repeat (11) step();
    credit_i = 1'b0;
    check("full_credits", 32'(credits_o), 32'd16);
    check("full_idle",    32'(idle_o),    32'd1);
    credit_i = 1'b1;
    step();
    credit_i = 1'b0;
    check("ovf_err",     32'(err_o),     32'd1);
    check("ovf_credits", 32'(credits_o), 32'd16);
    repeat (5) step();
    check("ovf_sticky", 32'(err_o), 32'd1);

    // Three words, drained without returning credits.
    valid_i = 1'b1;
    data_i  = 11'h101;
    step();
    data_i = 11'h102;
    step();
    data_i = 11'h103;
    step();
    valid_i = 1'b0;
    repeat (6) step();
    // Three more, then asynchronous reset while they are in flight.
    valid_i = 1'b1;
    data_i  = 11'h201;
    step();
    data_i = 11'h202;
    step();
    data_i = 11'h203;
    step();
    valid_i = 1'b0;
    check("pre_rst_credits", 32'(credits_o), 32'd10);
    #1;
    rst_ni = 1'b0;
    #1;
    check("async_lvalid",  32'(link_valid_o), 32'd0);
    check("async_credits", 32'(credits_o),    32'd16);
    check("async_err",     32'(err_o),        32'd0);
    check("async_idle",    32'(idle_o),       32'd1);
    repeat (2) step();
    rst_ni = 1'b1;
    repeat (10) step();
    check("post_rst_credits", 32'(credits_o), 32'd16);
    check("post_rst_err",     32'(err_o),     32'd0);
    check("post_rst_idle",    32'(idle_o),    32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/credit_link_tx.md
# credit_link_tx

Transmitter end of the team's credit-based stream link. Accepts a valid/ready stream, forwards each word across a fixed-latency register pipeline as a valid-only link (no back-pressure wire), and throttles itself with a credit counter replenished by pulses returned from the receiving buffer. Sits upstream of a credit-returning receive FIFO, typically across a long routing path or clock-region boundary on the same clock.

## Interface
- DATA_WIDTH, 11, payload width.
- CREDITS, 16, receiver buffer depth = initial credit count; must be >= 1.
- LINK_LATENCY, 4, forward register stages; must be >= 1.
- CNT_WIDTH (localparam), $clog2(CREDITS+1), credit counter width.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_i  in  DATA_WIDTH  input payload.
- valid_i  in  1  input word valid.
- ready_o  out  1  transmitter can accept a word.
- link_data_o  out  DATA_WIDTH  payload on link.
- link_valid_o  out  1  link word valid; receiver must accept it.
- credit_i  in  1  one-cycle pulse per freed receiver entry; at most one credit per cycle.
- credits_o  out  CNT_WIDTH  current credit count.
- idle_o  out  1  credits_o == CREDITS and no word in the pipeline.
- err_o  out  1  sticky credit-overflow flag.

## Operation
- Credit counter reg cnt, reset to CREDITS.
- ready_o = (cnt != 0); driven only from the cnt register, with no combinational path from credit_i or valid_i.
- accept = valid_i && ready_o.
- cnt_next = cnt - accept + credit_i, computed in CNT_WIDTH+1 bits.
- accept and credit_i in the same cycle: cnt unchanged.
- credit_i while cnt == CREDITS and no accept: overflow. cnt saturates at CREDITS and err_o is set. err_o clears only on reset.
- Forward pipeline: LINK_LATENCY stages, each holding a valid bit and a data register.
  - Stage 0 valid <= accept.
  - Stage 0 data loads data_i only on accept; otherwise it holds.
  - Stage i copies stage i-1 every cycle (no stall, no back-pressure).
  - link_valid_o / link_data_o are taken from the last stage.
- link_data_o while link_valid_o = 0 is the held last value and carries no meaning.
- Word order is strictly preserved. No word is ever dropped or duplicated.
- idle_o = (cnt == CREDITS) && (all stage valids == 0).

## Timing
- Reset (async assert, state released on the first clock edge after deassert):
  - cnt = CREDITS, ready_o = 1, credits_o = CREDITS.
  - All stage valids = 0, data = 0, so link_valid_o = 0 and link_data_o = 0.
  - err_o = 0, idle_o = 1.
- Reset mid-operation: in-flight words are discarded immediately and credits are restored to CREDITS. Resetting the receiver in the same window is the system's responsibility.
- Forward latency: a word accepted at edge N has link_valid_o high in the cycle after edge N+LINK_LATENCY-1, for exactly one cycle. With LINK_LATENCY=1 the output is registered directly after acceptance.
- Throughput: one word per cycle while cnt > 0.
- Credit-to-ready latency:
  - A credit_i sampled at edge M raises cnt, visible after M.
  - If cnt was 0, ready_o rises in the cycle after edge M.
- Exhaustion: after CREDITS accepts with no returned credits, ready_o = 0 in the next cycle.
- Back-to-back accepts at cnt == 1: the first accepts, then ready_o drops, unless credit_i arrives in that same cycle, in which case ready_o stays high.

## Test plan
- Reset release with defaults -> ready_o=1, credits_o=16, link_valid_o=0, idle_o=1, err_o=0.
- Single word 0x2A5 accepted at edge N, LINK_LATENCY=4 -> link_valid_o high for exactly one cycle, after edge N+3, with link_data_o=0x2A5; credits_o=15; idle_o=0 until the word exits and one credit returns.
- valid_i held high with 20 increasing words and no credit_i -> exactly 16 accepted (0..15), ready_o=0 from the 17th cycle, credits_o=0, link emits 0..15 in order. Then one credit_i pulse -> ready_o=1 next cycle, word 16 accepted.
- At credits_o=5, accept and credit_i in the same cycle -> credits_o stays 5, ready_o stays 1.
- credit_i pulse at credits_o=16 -> credits_o stays 16, err_o=1 and stays 1 until rst_ni is asserted.
- rst_ni asserted asynchronously with 3 words in flight and credits_o=10 -> link_valid_o drops immediately; after release credits_o=16 and none of the 3 words ever appears on the link.
